// File: rtl/multicycle_control_if.sv
// rtl/multicycle_control_if.sv - ALU op codes and control/datapath bundle for the multicycle controller
//
// multicycle_control_pkg : ALU operation codes shared by the controller, datapath and bench.
// multicycle_control_if  : instruction fields and flags from the datapath (i*), control
//                          strobes and selects back to it (o*).
//   master modport : datapath side (drives i*, receives o*)
//   slave modport  : controller side (receives i*, drives o*)

package multicycle_control_pkg;
  localparam logic [3:0] ALU_AND = 4'd0;
  localparam logic [3:0] ALU_OR  = 4'd1;
  localparam logic [3:0] ALU_ADD = 4'd2;
  localparam logic [3:0] ALU_SUB = 4'd6;
  localparam logic [3:0] ALU_SLT = 4'd7;
  localparam logic [3:0] ALU_FWD = 4'd8;
endpackage

interface multicycle_control_if;
  logic [6:0] iOpcode;
  logic [2:0] iFunct3;
  logic [6:0] iFunct7;
  logic       iZero;
  logic       iMemReady;
  logic [3:0] oState;
  logic [3:0] oALUControl;
  logic [1:0] oALUSrcA;
  logic [1:0] oALUSrcB;
  logic       oPCSource;
  logic [1:0] oMemtoReg;
  logic       oIorD;
  logic       oPCWrite;
  logic       oIRWrite;
  logic       oMemRead;
  logic       oMemWrite;
  logic       oRegWrite;
  logic       oHalt;

  modport master (
    output iOpcode, iFunct3, iFunct7, iZero, iMemReady,
    input  oState, oALUControl, oALUSrcA, oALUSrcB, oPCSource, oMemtoReg,
           oIorD, oPCWrite, oIRWrite, oMemRead, oMemWrite, oRegWrite, oHalt
  );

  modport slave (
    input  iOpcode, iFunct3, iFunct7, iZero, iMemReady,
    output oState, oALUControl, oALUSrcA, oALUSrcB, oPCSource, oMemtoReg,
           oIorD, oPCWrite, oIRWrite, oMemRead, oMemWrite, oRegWrite, oHalt
  );
endinterface

// File: rtl/multicycle_control.sv
// rtl/multicycle_control.sv - multicycle RISC-V subset control FSM
//
// Ports:
//   iCLK  : clock, all state changes on rising edge
//   iRSTn : asynchronous active-low reset, forces FETCH and silences all strobes
//   bus   : multicycle_control_if.slave - instruction fields, ALU zero, memory ready in;
//           state code, ALU op, mux selects, write/read enables and halt out

module multicycle_control
  import multicycle_control_pkg::*;
(
  input  logic                  iCLK,
  input  logic                  iRSTn,
  multicycle_control_if.slave   bus
);

  localparam logic [3:0] S_FETCH     = 4'd0;
  localparam logic [3:0] S_DECODE    = 4'd1;
  localparam logic [3:0] S_MEM_ADDR  = 4'd2;
  localparam logic [3:0] S_MEM_READ  = 4'd3;
  localparam logic [3:0] S_WB_MEM    = 4'd4;
  localparam logic [3:0] S_MEM_WRITE = 4'd5;
  localparam logic [3:0] S_EXEC_R    = 4'd6;
  localparam logic [3:0] S_EXEC_I    = 4'd7;
  localparam logic [3:0] S_WB_ALU    = 4'd8;
  localparam logic [3:0] S_BRANCH    = 4'd9;
  localparam logic [3:0] S_JAL       = 4'd10;
  localparam logic [3:0] S_LUI       = 4'd11;
  localparam logic [3:0] S_TRAP      = 4'd15;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  logic [3:0] state_q, state_d;
  // The instruction fields are only valid while decoding, so the ALU op for the
  // execute states and the beq/bne polarity are captured then.
  logic [3:0] alu_op_q, alu_op_d;
  logic       bne_q, bne_d;

  logic [3:0] dec_state;
  logic [3:0] dec_alu;
  logic       dec_bne;

  always_comb begin
    dec_state = S_TRAP;
    dec_alu   = ALU_ADD;
    dec_bne   = 1'b0;
    case (bus.iOpcode)
      OP_R: begin
        dec_state = S_EXEC_R;
        case ({bus.iFunct3, bus.iFunct7})
          {3'b000, 7'b0000000}: dec_alu = ALU_ADD;
          {3'b000, 7'b0100000}: dec_alu = ALU_SUB;
          {3'b111, 7'b0000000}: dec_alu = ALU_AND;
          {3'b110, 7'b0000000}: dec_alu = ALU_OR;
          {3'b010, 7'b0000000}: dec_alu = ALU_SLT;
          default:              dec_state = S_TRAP;
        endcase
      end
      OP_I: begin
        dec_state = S_EXEC_I;
        case (bus.iFunct3)
          3'b000:  dec_alu = ALU_ADD;
          3'b111:  dec_alu = ALU_AND;
          3'b110:  dec_alu = ALU_OR;
          3'b010:  dec_alu = ALU_SLT;
          default: dec_state = S_TRAP;
        endcase
      end
      OP_LOAD, OP_STORE: begin
        dec_state = (bus.iFunct3 == 3'b010) ? S_MEM_ADDR : S_TRAP;
      end
      OP_BRANCH: begin
        if (bus.iFunct3 == 3'b000) begin
          dec_state = S_BRANCH;
        end else if (bus.iFunct3 == 3'b001) begin
          dec_state = S_BRANCH;
          dec_bne   = 1'b1;
        end
      end
      OP_JAL:  dec_state = S_JAL;
      OP_LUI:  dec_state = S_LUI;
      default: dec_state = S_TRAP;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    alu_op_d = alu_op_q;
    bne_d    = bne_q;
    case (state_q)
      S_FETCH:     if (bus.iMemReady) state_d = S_DECODE;
      S_DECODE: begin
        state_d  = dec_state;
        alu_op_d = dec_alu;
        bne_d    = dec_bne;
      end
      // Opcode is looked at again here; anything that is neither load nor store
      // cannot legally reach this state, so it is treated as a trap.
      S_MEM_ADDR: begin
        if (bus.iOpcode == OP_LOAD)       state_d = S_MEM_READ;
        else if (bus.iOpcode == OP_STORE) state_d = S_MEM_WRITE;
        else                              state_d = S_TRAP;
      end
      S_MEM_READ:  if (bus.iMemReady) state_d = S_WB_MEM;
      S_MEM_WRITE: if (bus.iMemReady) state_d = S_FETCH;
      S_EXEC_R, S_EXEC_I, S_LUI: state_d = S_WB_ALU;
      S_WB_MEM, S_WB_ALU, S_BRANCH, S_JAL: state_d = S_FETCH;
      S_TRAP:      state_d = S_TRAP;
      default:     state_d = S_TRAP;
    endcase
  end

  always_ff @(posedge iCLK or negedge iRSTn) begin
    if (!iRSTn) begin
      state_q  <= S_FETCH;
      alu_op_q <= ALU_ADD;
      bne_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      alu_op_q <= alu_op_d;
      bne_q    <= bne_d;
    end
  end

  logic [3:0] alu_c;
  logic [1:0] src_a_c, src_b_c, m2r_c;
  logic       pcsrc_c, iord_c, pcw_c, irw_c, mr_c, mw_c, rw_c, halt_c;

  always_comb begin
    alu_c   = ALU_ADD;
    src_a_c = 2'd0;
    src_b_c = 2'd0;
    m2r_c   = 2'd0;
    pcsrc_c = 1'b0;
    iord_c  = 1'b0;
    pcw_c   = 1'b0;
    irw_c   = 1'b0;
    mr_c    = 1'b0;
    mw_c    = 1'b0;
    rw_c    = 1'b0;
    halt_c  = 1'b0;
    case (state_q)
      S_FETCH: begin
        mr_c    = 1'b1;
        src_b_c = 2'd1;
        irw_c   = bus.iMemReady;
        pcw_c   = bus.iMemReady;
      end
      S_DECODE: begin
        src_a_c = 2'd1;
        src_b_c = 2'd2;
      end
      S_MEM_ADDR: begin
        src_a_c = 2'd2;
        src_b_c = 2'd2;
      end
      S_MEM_READ: begin
        mr_c   = 1'b1;
        iord_c = 1'b1;
      end
      S_WB_MEM: begin
        rw_c  = 1'b1;
        m2r_c = 2'd1;
      end
      S_MEM_WRITE: begin
        mw_c   = 1'b1;
        iord_c = 1'b1;
      end
      S_EXEC_R: begin
        src_a_c = 2'd2;
        alu_c   = alu_op_q;
      end
      S_EXEC_I: begin
        src_a_c = 2'd2;
        src_b_c = 2'd2;
        alu_c   = alu_op_q;
      end
      S_LUI: begin
        src_b_c = 2'd2;
        alu_c   = ALU_FWD;
      end
      S_WB_ALU: rw_c = 1'b1;
      S_BRANCH: begin
        src_a_c = 2'd2;
        alu_c   = ALU_SUB;
        pcsrc_c = 1'b1;
        pcw_c   = bne_q ? ~bus.iZero : bus.iZero;
      end
      S_JAL: begin
        rw_c    = 1'b1;
        m2r_c   = 2'd2;
        pcw_c   = 1'b1;
        pcsrc_c = 1'b1;
      end
      default: halt_c = 1'b1;
    endcase
  end

  // While reset is held the state register already reads FETCH, but FETCH
  // asserts a read; everything is gated here so the bus stays quiet in reset.
  always_comb begin
    bus.oState      = iRSTn ? state_q : S_FETCH;
    bus.oALUControl = iRSTn ? alu_c   : ALU_ADD;
    bus.oALUSrcA    = iRSTn ? src_a_c : 2'd0;
    bus.oALUSrcB    = iRSTn ? src_b_c : 2'd0;
    bus.oPCSource   = iRSTn & pcsrc_c;
    bus.oMemtoReg   = iRSTn ? m2r_c   : 2'd0;
    bus.oIorD       = iRSTn & iord_c;
    bus.oPCWrite    = iRSTn & pcw_c;
    bus.oIRWrite    = iRSTn & irw_c;
    bus.oMemRead    = iRSTn & mr_c;
    bus.oMemWrite   = iRSTn & mw_c;
    bus.oRegWrite   = iRSTn & rw_c;
    bus.oHalt       = iRSTn & halt_c;
  end

endmodule

// File: tb/tb_multicycle_control.sv
// tb/tb_multicycle_control.sv - scoreboard bench for multicycle_control

module tb_multicycle_control;
  import multicycle_control_pkg::*;

  typedef struct packed {
    logic [3:0] st;
    logic [3:0] alu;
    logic [1:0] sa;
    logic [1:0] sb;
    logic       pcs;
    logic [1:0] m2r;
    logic       iord;
    logic       pcw;
    logic       irw;
    logic       mr;
    logic       mw;
    logic       rw;
    logic       halt;
  } rec_t;

  localparam int K_R = 0, K_I = 1, K_LW = 2, K_SW = 3, K_BR = 4, K_JAL = 5, K_LUI = 6, K_TRAP = 7;

  logic iCLK;
  logic iRSTn;
  multicycle_control_if bus ();

  multicycle_control dut (
    .iCLK  (iCLK),
    .iRSTn (iRSTn),
    .bus   (bus.slave)
  );

  initial iCLK = 1'b0;
  always #5 iCLK = ~iCLK;

  rec_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   cyc = 0;

  always @(negedge iCLK) begin
    rec_t e, a;
    cyc++;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a = rec_t'({bus.oState, bus.oALUControl, bus.oALUSrcA, bus.oALUSrcB, bus.oPCSource,
                  bus.oMemtoReg, bus.oIorD, bus.oPCWrite, bus.oIRWrite, bus.oMemRead,
                  bus.oMemWrite, bus.oRegWrite, bus.oHalt});
      n_checks++;
      if (a !== e) begin
        n_errors++;
        $display("FAIL outputs@cycle%0d: actual state=%0d alu=%0d vec=%h, required state=%0d alu=%0d vec=%h",
                 cyc, a.st, a.alu, a, e.st, e.alu, e);
      end
    end
  end

  function automatic rec_t mk(input logic [3:0] st);
    rec_t r;
    r = '0;
    r.st  = st;
    r.alu = ALU_ADD;
    return r;
  endfunction

  // Instruction classes as the ISA subset defines them.
  function automatic void classify(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                                   output int kind, output logic [3:0] alu);
    kind = K_TRAP;
    alu  = ALU_ADD;
    if (op == 7'b0110011) begin
      if (f7 == 7'b0100000 && f3 == 3'b000) begin kind = K_R; alu = ALU_SUB; end
      else if (f7 == 7'd0) begin
        if (f3 == 3'b000)      begin kind = K_R; alu = ALU_ADD; end
        else if (f3 == 3'b111) begin kind = K_R; alu = ALU_AND; end
        else if (f3 == 3'b110) begin kind = K_R; alu = ALU_OR;  end
        else if (f3 == 3'b010) begin kind = K_R; alu = ALU_SLT; end
      end
    end else if (op == 7'b0010011) begin
      if (f3 == 3'b000)      begin kind = K_I; alu = ALU_ADD; end
      else if (f3 == 3'b111) begin kind = K_I; alu = ALU_AND; end
      else if (f3 == 3'b110) begin kind = K_I; alu = ALU_OR;  end
      else if (f3 == 3'b010) begin kind = K_I; alu = ALU_SLT; end
    end else if (op == 7'b0000011 && f3 == 3'b010) kind = K_LW;
    else if (op == 7'b0100011 && f3 == 3'b010) kind = K_SW;
    else if (op == 7'b1100011 && (f3 == 3'b000 || f3 == 3'b001)) kind = K_BR;
    else if (op == 7'b1101111) kind = K_JAL;
    else if (op == 7'b0110111) kind = K_LUI;
  endfunction

  task automatic step(input rec_t e, input logic rdy, input logic z, input logic rst,
                      input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7);
    @(posedge iCLK);
    #1;
    iRSTn         = rst;
    bus.iMemReady = rdy;
    bus.iZero     = z;
    bus.iOpcode   = op;
    bus.iFunct3   = f3;
    bus.iFunct7   = f7;
    exp_q.push_back(e);
  endtask

  // Cycle where the instruction fields must be ignored: drive garbage.
  task automatic step_g(input rec_t e, input logic rdy, input logic z);
    step(e, rdy, z, 1'b1, 7'($urandom), 3'($urandom), 7'($urandom));
  endtask

  task automatic step_reset();
    step(mk(4'd0), 1'($urandom), 1'($urandom), 1'b0, 7'($urandom), 3'($urandom), 7'($urandom));
  endtask

  task automatic run_instr(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                           input int fw, input int mw, input int zsel, input bit mid_rst,
                           input int trap_len);
    rec_t e;
    int kind;
    logic [3:0] alu;
    logic z;
    for (int i = 0; i < fw; i++) begin
      e = mk(4'd0); e.mr = 1; e.sb = 2'd1;
      step_g(e, 1'b0, 1'($urandom));
    end
    e = mk(4'd0); e.mr = 1; e.sb = 2'd1; e.irw = 1; e.pcw = 1;
    step_g(e, 1'b1, 1'($urandom));
    e = mk(4'd1); e.sa = 2'd1; e.sb = 2'd2;
    step(e, 1'($urandom), 1'($urandom), 1'b1, op, f3, f7);
    classify(op, f3, f7, kind, alu);
    case (kind)
      K_R, K_I, K_LUI: begin
        if (kind == K_R)      begin e = mk(4'd6);  e.sa = 2'd2; e.alu = alu; end
        else if (kind == K_I) begin e = mk(4'd7);  e.sa = 2'd2; e.sb = 2'd2; e.alu = alu; end
        else                  begin e = mk(4'd11); e.sb = 2'd2; e.alu = ALU_FWD; end
        step_g(e, 1'($urandom), 1'($urandom));
        e = mk(4'd8); e.rw = 1;
        step_g(e, 1'($urandom), 1'($urandom));
      end
      K_LW, K_SW: begin
        e = mk(4'd2); e.sa = 2'd2; e.sb = 2'd2;
        step(e, 1'($urandom), 1'($urandom), 1'b1, op, 3'($urandom), 7'($urandom));
        e = (kind == K_LW) ? mk(4'd3) : mk(4'd5);
        e.iord = 1;
        if (kind == K_LW) e.mr = 1; else e.mw = 1;
        for (int i = 0; i < mw; i++) step_g(e, 1'b0, 1'($urandom));
        if (mid_rst) begin
          step_reset();
          return;
        end
        step_g(e, 1'b1, 1'($urandom));
        if (kind == K_LW) begin
          e = mk(4'd4); e.rw = 1; e.m2r = 2'd1;
          step_g(e, 1'($urandom), 1'($urandom));
        end
      end
      K_BR: begin
        z = (zsel < 0) ? 1'($urandom) : 1'(zsel);
        e = mk(4'd9); e.sa = 2'd2; e.alu = ALU_SUB; e.pcs = 1;
        e.pcw = (f3 == 3'b001) ? ~z : z;
        step_g(e, 1'($urandom), z);
      end
      K_JAL: begin
        e = mk(4'd10); e.rw = 1; e.m2r = 2'd2; e.pcw = 1; e.pcs = 1;
        step_g(e, 1'($urandom), 1'($urandom));
      end
      default: begin
        e = mk(4'd15); e.halt = 1;
        for (int i = 0; i < trap_len; i++) step_g(e, 1'($urandom), 1'($urandom));
        step_reset();
      end
    endcase
  endtask

  logic [6:0] op_tab [8];
  logic [2:0] f3_tab [5];

  initial begin
    logic [6:0] op, f7;
    logic [2:0] f3;
    op_tab = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011,
               7'b1100011, 7'b1101111, 7'b0110111, 7'b0000000};
    f3_tab = '{3'b000, 3'b111, 3'b110, 3'b010, 3'b001};
    iRSTn = 1'b0;
    bus.iMemReady = 1'b0;
    bus.iZero = 1'b0;
    bus.iOpcode = '0;
    bus.iFunct3 = '0;
    bus.iFunct7 = '0;
    step_reset();
    step_reset();

    run_instr(7'b0110011, 3'b000, 7'b0100000, 0, 0, -1, 1'b0, 0);
    run_instr(7'b0000011, 3'b010, 7'h55,      0, 3, -1, 1'b0, 0);
    run_instr(7'b1100011, 3'b000, 7'h00,      0, 0,  1, 1'b0, 0);
    run_instr(7'b1100011, 3'b000, 7'h00,      0, 0,  0, 1'b0, 0);
    run_instr(7'b1100011, 3'b001, 7'h00,      0, 0,  1, 1'b0, 0);
    run_instr(7'b1100011, 3'b001, 7'h00,      0, 0,  0, 1'b0, 0);
    run_instr(7'b0010011, 3'b110, 7'h13,      2, 0, -1, 1'b0, 0);
    run_instr(7'b0000011, 3'b010, 7'h00,      1, 2, -1, 1'b1, 0);
    run_instr(7'b0100011, 3'b010, 7'h00,      0, 1, -1, 1'b0, 0);
    run_instr(7'b1101111, 3'b101, 7'h7f,      0, 0, -1, 1'b0, 0);
    run_instr(7'b0110111, 3'b011, 7'h01,      0, 0, -1, 1'b0, 0);
    run_instr(7'b0110011, 3'b001, 7'h00,      0, 0, -1, 1'b0, 3);
    run_instr(7'b0000000, 3'b000, 7'h00,      0, 0, -1, 1'b0, 100);

    for (int n = 0; n < 300; n++) begin
      op = ($urandom_range(0, 9) == 0) ? 7'($urandom) : op_tab[$urandom_range(0, 7)];
      f3 = ($urandom_range(0, 3) != 0) ? f3_tab[$urandom_range(0, 4)] : 3'($urandom);
      case ($urandom_range(0, 4))
        0, 1, 2: f7 = 7'd0;
        3:       f7 = 7'b0100000;
        default: f7 = 7'($urandom);
      endcase
      run_instr(op, f3, f7, $urandom_range(0, 3), $urandom_range(0, 3), -1,
                ($urandom_range(0, 7) == 0), $urandom_range(1, 6));
    end

    repeat (3) @(posedge iCLK);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_errors++;
      $display("FAIL scoreboard_drain: actual %0d pending, required 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
